// File: rtl/vector_response_checker_pkg.sv
// vector_response_checker_pkg: shared state encoding and default widths for the vector response checker.
package vector_response_checker_pkg;
    localparam int DEF_VEC_W = 6;
    localparam int DEF_CNT_W = 8;
    typedef enum logic [2:0] {ST_IDLE, ST_WAIT_VEC, ST_SETTLE, ST_CHECK, ST_DONE} state_e;
endpackage

// File: rtl/vector_response_checker_settle_timer.sv
// vector_response_checker_settle_timer: load/decrement countdown that expires after SETTLE cycles.
module vector_response_checker_settle_timer #(
    parameter int SETTLE = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic load_i,
    input  logic dec_i,
    output logic expired_o
);
    localparam int CW = SETTLE > 1 ? $clog2(SETTLE) : 1;
    localparam logic [CW-1:0] LOAD = CW'(SETTLE > 0 ? SETTLE - 1 : 0);
    logic [CW-1:0] cnt_q;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) cnt_q <= '0;
        else if (load_i) cnt_q <= LOAD;
        else if (dec_i && cnt_q != '0) cnt_q <= cnt_q - 1'b1;
    end
    assign expired_o = cnt_q == '0;
endmodule

// File: rtl/vector_response_checker.sv
// vector_response_checker: drives test vectors to three DUT implementations, compares their outputs
// after a settle interval and reports mismatch count, first failing vector and pass/fail.
module vector_response_checker
    import vector_response_checker_pkg::*;
#(
    parameter int VEC_W   = DEF_VEC_W,
    parameter int SETTLE  = 2,
    parameter int NUM_VEC = 4,
    parameter int CNT_W   = DEF_CNT_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             vec_valid,
    output logic             vec_ready,
    input  logic [VEC_W-1:0] vec,
    output logic [VEC_W-1:0] drv_vec,
    input  logic             out_df,
    input  logic             out_b,
    input  logic             out_g,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [CNT_W-1:0] vec_count,
    output logic [CNT_W-1:0] err_count,
    output logic             first_err_valid,
    output logic [VEC_W-1:0] first_err_vec
);
    state_e           state_q;
    logic             ready_q, busy_q, done_q, pass_q, fev_q;
    logic [VEC_W-1:0] drv_q, fe_vec_q;
    logic [CNT_W-1:0] vcnt_q, ecnt_q;
    logic             mismatch, accept, expired;
    logic [CNT_W-1:0] vcnt_d;

    assign mismatch = (out_df != out_b) | (out_b != out_g);
    assign accept   = state_q == ST_WAIT_VEC && vec_valid;
    assign vcnt_d   = vcnt_q + CNT_W'(1);

    vector_response_checker_settle_timer #(.SETTLE(SETTLE)) u_timer (
        .clk      (clk),
        .rst_n    (rst_n),
        .load_i   (accept),
        .dec_i    (state_q == ST_SETTLE),
        .expired_o(expired)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            ready_q  <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            pass_q   <= 1'b0;
            fev_q    <= 1'b0;
            drv_q    <= '0;
            fe_vec_q <= '0;
            vcnt_q   <= '0;
            ecnt_q   <= '0;
        end else begin
            case (state_q)
                ST_IDLE, ST_DONE: if (start) begin
                    state_q  <= ST_WAIT_VEC;
                    ready_q  <= 1'b1;
                    busy_q   <= 1'b1;
                    done_q   <= 1'b0;
                    pass_q   <= 1'b0;
                    fev_q    <= 1'b0;
                    fe_vec_q <= '0;
                    vcnt_q   <= '0;
                    ecnt_q   <= '0;
                end
                ST_WAIT_VEC: if (vec_valid) begin
                    drv_q   <= vec;
                    ready_q <= 1'b0;
                    state_q <= SETTLE == 0 ? ST_CHECK : ST_SETTLE;
                end
                ST_SETTLE: if (expired) state_q <= ST_CHECK;
                ST_CHECK: begin
                    vcnt_q <= vcnt_d;
                    if (mismatch && ecnt_q != '1) ecnt_q <= ecnt_q + CNT_W'(1);
                    if (mismatch && !fev_q) begin
                        fev_q    <= 1'b1;
                        fe_vec_q <= drv_q;
                    end
                    // Saturating err_count never wraps, so zero now and no new mismatch means a clean run.
                    if (vcnt_d == CNT_W'(NUM_VEC)) begin
                        state_q <= ST_DONE;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        pass_q  <= ecnt_q == '0 && !mismatch;
                    end else begin
                        state_q <= ST_WAIT_VEC;
                        ready_q <= 1'b1;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign vec_ready       = ready_q;
    assign busy            = busy_q;
    assign done            = done_q;
    assign pass            = pass_q;
    assign drv_vec         = drv_q;
    assign vec_count       = vcnt_q;
    assign err_count       = ecnt_q;
    assign first_err_valid = fev_q;
    assign first_err_vec   = fe_vec_q;
endmodule

// File: tb/tb_vector_response_checker.sv
// tb_vector_response_checker: scoreboard bench; three modelled DUTs with injectable faults feed the checker.
module tb_vector_response_checker;
    localparam int SETTLE  = 2;
    localparam int NUM_VEC = 4;

    typedef struct {
        logic [7:0] vc;
        logic [7:0] ec;
        logic       fvv;
        logic [5:0] fv;
        logic       ps;
    } exp_t;

    logic clk = 1'b0, rst_n = 1'b0, start = 1'b0, vec_valid = 1'b0;
    logic [5:0] vec = '0;
    logic vec_ready, out_df, out_b, out_g, busy, done, pass, first_err_valid;
    logic [5:0] drv_vec, first_err_vec;
    logic [7:0] vec_count, err_count;
    logic cur_fb = 1'b0, cur_fg = 1'b0;

    logic [5:0] vecs [NUM_VEC];
    bit fb [NUM_VEC];
    bit fg [NUM_VEC];
    exp_t exp_q [$];
    int total = 0, bad = 0;

    vector_response_checker #(.VEC_W(6), .SETTLE(SETTLE), .NUM_VEC(NUM_VEC), .CNT_W(8)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .vec_valid(vec_valid), .vec_ready(vec_ready),
        .vec(vec), .drv_vec(drv_vec), .out_df(out_df), .out_b(out_b), .out_g(out_g),
        .busy(busy), .done(done), .pass(pass), .vec_count(vec_count), .err_count(err_count),
        .first_err_valid(first_err_valid), .first_err_vec(first_err_vec)
    );

    always #5 clk = ~clk;

    function automatic logic hw_f(input logic [5:0] v);
        return (v[5] & v[4]) | (v[3] ^ v[2]) | (v[1] & ~v[0]);
    endfunction

    assign out_df = hw_f(drv_vec);
    assign out_b  = hw_f(drv_vec) ^ cur_fb;
    assign out_g  = hw_f(drv_vec) ^ cur_fg;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [63:0] all_outs();
        return {31'd0, busy, done, pass, vec_ready, drv_vec, vec_count, err_count, first_err_valid, first_err_vec};
    endfunction

    initial begin : monitor
        logic done_prev = 1'b0;
        exp_t e;
        forever begin
            @(negedge clk);
            if (rst_n && done && !done_prev) begin
                if (exp_q.size() == 0) chk("unexpected_done", 1, 0);
                else begin
                    e = exp_q.pop_front();
                    chk("vec_count", vec_count, e.vc);
                    chk("err_count", err_count, e.ec);
                    chk("first_err_valid", first_err_valid, e.fvv);
                    chk("first_err_vec", first_err_vec, e.fv);
                    chk("pass", pass, e.ps);
                    chk("busy_at_done", busy, 0);
                end
            end
            if (!done) chk("pass_without_done", pass, 0);
            done_prev = done;
        end
    end

    task automatic run(input bit hold, input int rst_slot);
        int err = 0, n;
        bit fvv = 0, ok, stable;
        logic [5:0] fv = '0;
        vec = vecs[0];
        vec_valid = hold;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        chk("start_busy", busy, 1);
        chk("start_ready_no_accept", vec_ready, 1);
        chk("start_clear", {done, pass, vec_count, err_count, first_err_valid, first_err_vec}, 0);
        for (int i = 0; i < NUM_VEC; i++) begin
            vec = vecs[i];
            vec_valid = 1'b1;
            ok = 0;
            for (int k = 0; k < 100 && !ok; k++) begin
                @(negedge clk);
                ok = vec_ready;
            end
            if (!ok) begin
                chk("accept_timeout", 0, 1);
                vec_valid = 1'b0;
                return;
            end
            @(posedge clk); #1;
            cur_fb = fb[i];
            cur_fg = fg[i];
            if (!hold) vec_valid = 1'b0;
            chk("drv_vec", drv_vec, vecs[i]);
            if (fb[i] | fg[i]) begin
                err++;
                if (!fvv) begin
                    fvv = 1;
                    fv = vecs[i];
                end
            end
            if (i == rst_slot) begin
                @(negedge clk);
                rst_n = 1'b0;
                #1 chk("reset_mid_run", all_outs(), 0);
                @(posedge clk); #1;
                rst_n = 1'b1;
                vec_valid = 1'b0;
                return;
            end
            if (i == NUM_VEC - 1) exp_q.push_back('{8'(NUM_VEC), 8'(err > 255 ? 255 : err), fvv, fv, err == 0});
            n = 1;
            stable = 1;
            while (!vec_ready && !done && n < 100) begin
                start = hold && i == 1 && n == 2;
                @(posedge clk); #1;
                n++;
                if (drv_vec !== vecs[i]) stable = 0;
            end
            start = 1'b0;
            chk("drv_hold", stable, 1);
            chk("latency", n, SETTLE + 2);
            chk("vec_count_step", vec_count, i + 1);
            if (!hold) repeat ($urandom_range(0, 2)) begin
                @(posedge clk); #1;
            end
        end
        repeat (3) begin
            @(posedge clk); #1;
        end
        chk("count_capped", vec_count, NUM_VEC);
        chk("done_level", done, 1);
        chk("drv_after_done", drv_vec, vecs[NUM_VEC-1]);
    endtask

    task automatic clear_faults();
        for (int i = 0; i < NUM_VEC; i++) begin
            fb[i] = 0;
            fg[i] = 0;
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        vecs[0] = 6'b000000;
        vecs[1] = 6'b111111;
        vecs[2] = 6'b010101;
        vecs[3] = 6'b101010;
        clear_faults();
        #12 chk("reset_outputs", all_outs(), 0);
        rst_n = 1'b1;
        @(posedge clk); #1;
        chk("idle_after_reset", {busy, vec_ready}, 0);
        run(0, -1);
        fg[2] = 1;
        run(1, -1);
        clear_faults();
        fb[1] = 1;
        fb[3] = 1;
        run(0, -1);
        clear_faults();
        run(0, 2);
        run(0, -1);
        run(1, -1);
        for (int r = 0; r < 6; r++) begin
            for (int i = 0; i < NUM_VEC; i++) begin
                vecs[i] = 6'($urandom_range(0, 63));
                fb[i] = $urandom_range(0, 3) == 0;
                fg[i] = $urandom_range(0, 3) == 0;
            end
            run(1'($urandom_range(0, 1)), -1);
        end
        repeat (3) @(posedge clk);
        #1 chk("queue_empty", exp_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
